// File: rtl/npc_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Latency: none, declarations only.
// Backpressure: not applicable.
package npc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } ifu_state_t;

  localparam int          INST_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/npc_ifu.sv
// Instruction fetch: owns the PC, issues one memory read at a time, buffers the word for the core.
// Latency: request accepted in N, response in N+1, inst_valid in N+2 (1 inst per 3 cycles at best).
// Backpressure: inst_ready low holds the buffered word and stalls fetch; req_ready low holds the request.
module npc_ifu #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(npc_pkg::RESET_PC),
  parameter int                CNT_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        req_valid,
  input  logic                        req_ready,
  output logic [ADDR_W-1:0]           req_addr,
  input  logic                        resp_valid,
  input  logic [npc_pkg::INST_W-1:0]  resp_data,
  output logic                        inst_valid,
  input  logic                        inst_ready,
  output logic [npc_pkg::INST_W-1:0]  inst,
  output logic [ADDR_W-1:0]           inst_pc,
  input  logic                        redirect_valid,
  input  logic [ADDR_W-1:0]           redirect_pc,
  output logic [CNT_W-1:0]            fetch_count
);
  import npc_pkg::*;

  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  ifu_state_t        state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic              drop, drop_nxt;
  logic              buf_load;
  logic              inst_hs;
  logic [ADDR_W-1:0] redir_pc;

  // Redirect targets are always word aligned.
  assign redir_pc = redirect_pc & ALIGN_MASK;

  // Request side is decoded from registered state only.
  assign req_valid = (state == REQ);
  assign req_addr  = pc;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, next PC, stale-response tracking and buffer/handshake strobes.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    drop_nxt  = drop;
    buf_load  = 1'b0;
    inst_hs   = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (redirect_valid) pc_nxt = redir_pc;
        if (req_ready) begin
          state_nxt = WAIT;
          // A request accepted alongside a redirect targets the old PC.
          drop_nxt  = redirect_valid;
        end
      end
      WAIT: begin
        if (resp_valid) begin
          drop_nxt = 1'b0;
          if (redirect_valid) begin
            pc_nxt    = redir_pc;
            state_nxt = REQ;
          end else if (drop) begin
            state_nxt = REQ;
          end else begin
            buf_load  = 1'b1;
            state_nxt = HOLD;
          end
        end else if (redirect_valid) begin
          // The in-flight response is now stale; discard it when it lands.
          pc_nxt   = redir_pc;
          drop_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (inst_ready) begin
          inst_hs   = 1'b1;
          pc_nxt    = pc + PC_STEP;
          state_nxt = REQ;
        end
        // Redirect overrides the sequential PC even when the handshake completes.
        if (redirect_valid) begin
          pc_nxt    = redir_pc;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // PC and stale-response flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc   <= RESET_PC;
      drop <= 1'b0;
    end else begin
      pc   <= pc_nxt;
      drop <= drop_nxt;
    end
  end

  // One-entry instruction buffer presented to the core.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_valid <= 1'b0;
      inst       <= INST_NOP;
      inst_pc    <= RESET_PC;
    end else begin
      inst_valid <= (state_nxt == HOLD);
      if (buf_load) begin
        inst    <= resp_data;
        inst_pc <= pc;
      end
    end
  end

  // Count of instructions handed to the core.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count <= '0;
    end else if (inst_hs) begin
      fetch_count <= fetch_count + CNT_W'(1);
    end
  end

endmodule
